// File: rtl/ddr_frame_pkg.sv
// Shared definitions for the camera-to-DDR frame writer: state encoding,
// default geometry and DDR command field widths.
package ddr_frame_pkg;

  // Default geometry: 640x480 at 16 bpp packed into 64-bit words
  localparam int DEF_BURST_LEN   = 64;
  localparam int DEF_FRAME_WORDS = 76800;

  // DDR command channel field widths
  localparam int ADDR_W = 30;  // byte address
  localparam int BL_W   = 7;   // burst length minus one, and burst word counter

  // Write engine states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,  // armed, waiting for a frame-start edge
    ST_WAIT_DATA = 2'd1,  // waiting for enough buffered words for the next burst
    ST_DATA      = 2'd2,  // streaming burst words on the write-data channel
    ST_CMD       = 2'd3   // presenting the write command for the burst just sent
  } wr_state_e;

endpackage

// File: rtl/wr_fifo_sync.sv
// Single-clock first-word-fall-through word buffer with level output.
// The head word is always visible on data_o while level_o is non-zero.
// A flush empties the buffer; a push in the same cycle becomes the new head.
// DEPTH must be a power of two.
module wr_fifo_sync #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             do_push, do_pop;
  logic [PTR_W-1:0] wr_idx;

  assign full_o  = (level_q == (PTR_W + 1)'(DEPTH));
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A flush frees the whole buffer, so a coincident push is always accepted
  assign do_push = push_i && (!full_o || flush_i);
  assign do_pop  = pop_i && (level_q != '0) && !flush_i;
  assign wr_idx  = flush_i ? '0 : wr_ptr_q;

  // Pointer and level bookkeeping for push, pop and flush
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = do_push ? PTR_W'(1) : '0;
      level_d  = do_push ? (PTR_W + 1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + (PTR_W + 1)'(1);
        2'b01:   level_d = level_q - (PTR_W + 1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Word storage; contents need no reset because the level gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/frame_write_burst.sv
// Camera frame writer: buffers packed pixel words and issues them to DDR as
// write bursts (data beats first, then the matching write command).
// Optional macro FRAME_PINGPONG_EN alternates frames between two buffers;
// without it every frame is written at BASE_ADDR and wr_bank stays 0.
module frame_write_burst
  import ddr_frame_pkg::*;
#(
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int BASE_ADDR   = 0,
  parameter int FIFO_DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              vin_vs,
  input  logic              pix_we,
  input  logic [63:0]       pix_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [63:0]       wr_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [BL_W-1:0]   cmd_bl,
  output logic              frame_write_done,
  output logic              overflow,
  output logic              wr_bank
);

  localparam int                WCNT_W      = $clog2(FRAME_WORDS + 1);
  localparam int                LVL_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE_A      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(FRAME_WORDS * 8);
  localparam logic [WCNT_W-1:0] WORDS_FULL  = WCNT_W'(FRAME_WORDS);

  wr_state_e         state_q, state_d;
  logic              vs_q;
  logic [WCNT_W-1:0] words_q, words_d;   // words committed by completed commands
  logic [ADDR_W-1:0] addr_q, addr_d;     // byte address of the current burst
  logic [BL_W-1:0]   bl_q, bl_d;         // presented burst length minus one
  logic [BL_W-1:0]   bcnt_q, bcnt_d;     // words sent in the current burst
  logic              abort_q, abort_d;   // pending command closes an abandoned frame
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              bank_q, bank_d;

  logic              vs_rise, start, flush, push_en, pop;
  logic              fifo_full;
  logic [LVL_W-1:0]  fifo_level;
  logic [WCNT_W-1:0] remaining;
  logic [BL_W-1:0]   target;
  logic [BL_W-1:0]   sent_k;
  logic [WCNT_W-1:0] words_sum;
  logic [ADDR_W-1:0] base_cur, base_next;
  logic              bank_flip;

  assign vs_rise = vin_vs && !vs_q;
  assign start   = vs_rise && init_done;
  // Pixels count only once a frame is under way; the start cycle itself
  // delivers word 0 of the new frame
  assign push_en = pix_we && init_done && ((state_q != ST_IDLE) || vs_rise);
  assign flush   = start || !init_done;
  assign pop     = (state_q == ST_DATA) && wr_ready;

  assign sent_k    = bcnt_q + BL_W'(pop);
  assign words_sum = words_q + WCNT_W'(bcnt_q);

`ifdef FRAME_PINGPONG_EN
  assign base_cur  = bank_q ? (BASE_A + FRAME_BYTES) : BASE_A;
  assign base_next = bank_q ? BASE_A : (BASE_A + FRAME_BYTES);
  assign bank_flip = !bank_q;
`else
  assign base_cur  = BASE_A;
  assign base_next = BASE_A;
  assign bank_flip = 1'b0;
`endif

  assign wr_valid         = (state_q == ST_DATA);
  assign cmd_valid        = (state_q == ST_CMD);
  assign cmd_addr         = addr_q;
  assign cmd_bl           = bl_q;
  assign frame_write_done = done_q;
  assign overflow         = ovf_q;
  assign wr_bank          = bank_q;

  wr_fifo_sync #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push_en),
    .data_i  (pix_data),
    .pop_i   (pop),
    .data_o  (wr_data),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  // Size of the next burst: a full burst, or whatever is left of the frame
  always_comb begin
    remaining = WORDS_FULL - words_q;
    if (32'(remaining) >= BURST_LEN) target = BL_W'(BURST_LEN);
    else                             target = BL_W'(remaining);
  end

  // Registered vsync copy for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_q <= 1'b0;
    else        vs_q <= vin_vs;
  end

  // Next-state logic for the burst engine and its counters
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    addr_d  = addr_q;
    bl_d    = bl_q;
    bcnt_d  = bcnt_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    bank_d  = bank_q;

    if (push_en && fifo_full && !flush) ovf_d = 1'b1;

    if (!init_done) begin
      // Calibration lost: drop everything, outstanding handshakes included
      state_d = ST_IDLE;
      words_d = '0;
      addr_d  = base_cur;
      bcnt_d  = '0;
      abort_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vs_rise) begin
            state_d = ST_WAIT_DATA;
            words_d = '0;
            addr_d  = base_cur;
            bcnt_d  = '0;
          end
        end
        ST_WAIT_DATA: begin
          if (vs_rise) begin
            words_d = '0;
            addr_d  = base_cur;
            bcnt_d  = '0;
          end else if (32'(fifo_level) >= 32'(target)) begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (pop) bcnt_d = bcnt_q + BL_W'(1);
          if (vs_rise) begin
            if (sent_k != '0) begin
              // Words already on the bus still need their command
              state_d = ST_CMD;
              bl_d    = sent_k - BL_W'(1);
              bcnt_d  = sent_k;
              abort_d = 1'b1;
            end else begin
              state_d = ST_WAIT_DATA;
              words_d = '0;
              addr_d  = base_cur;
              bcnt_d  = '0;
            end
          end else if (pop && (bcnt_q + BL_W'(1) == target)) begin
            state_d = ST_CMD;
            bl_d    = target - BL_W'(1);
          end
        end
        ST_CMD: begin
          if (vs_rise) abort_d = 1'b1;
          if (cmd_ready) begin
            state_d = ST_WAIT_DATA;
            bcnt_d  = '0;
            if (abort_q || vs_rise) begin
              words_d = '0;
              addr_d  = base_cur;
              abort_d = 1'b0;
            end else if (words_sum == WORDS_FULL) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              bank_d  = bank_flip;
              words_d = '0;
              addr_d  = base_next;
            end else begin
              words_d = words_sum;
              addr_d  = addr_q + ADDR_W'({bcnt_q, 3'b000});
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (start) ovf_d = 1'b0;
  end

  // Engine state, counters and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      words_q <= '0;
      addr_q  <= BASE_A;
      bl_q    <= '0;
      bcnt_q  <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      bl_q    <= bl_d;
      bcnt_q  <= bcnt_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      bank_q  <= bank_d;
    end
  end

endmodule

// File: tb/tb_frame_write_burst.sv
// Scoreboard bench for frame_write_burst with a small frame geometry
// (16-word bursts, 40-word frames, 32-word buffer, base 0x1000).
module tb_frame_write_burst;

  localparam int TB_BURST = 16;
  localparam int TB_FRAME = 40;
  localparam int TB_DEPTH = 32;
  localparam int TB_BASE  = 'h1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        vin_vs;
  logic        pix_we;
  logic [63:0] pix_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [29:0] cmd_addr;
  logic [6:0]  cmd_bl;
  logic        frame_write_done;
  logic        overflow;
  logic        wr_bank;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_exp = 0;
  logic bank_m = 1'b0;

  logic [63:0] exp_data_q[$];
  logic [29:0] exp_addr_q[$];
  logic [6:0]  exp_bl_q[$];

  frame_write_burst #(
    .BURST_LEN   (TB_BURST),
    .FRAME_WORDS (TB_FRAME),
    .BASE_ADDR   (TB_BASE),
    .FIFO_DEPTH  (TB_DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .init_done        (init_done),
    .vin_vs           (vin_vs),
    .pix_we           (pix_we),
    .pix_data         (pix_data),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_data          (wr_data),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_addr         (cmd_addr),
    .cmd_bl           (cmd_bl),
    .frame_write_done (frame_write_done),
    .overflow         (overflow),
    .wr_bank          (wr_bank)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mkword(input logic [7:0] tag, input int i);
    return {8'hA5, tag, 16'h0000, i[31:0]};
  endfunction

  function automatic logic [29:0] frame_base(input logic bank);
`ifdef FRAME_PINGPONG_EN
    return bank ? 30'(TB_BASE + TB_FRAME * 8) : 30'(TB_BASE);
`else
    return (bank === 1'bx) ? 30'h0 : 30'(TB_BASE);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Expected beats and commands for one complete frame
  task automatic expect_frame(input logic [7:0] tag);
    logic [29:0] base;
    int len;
    base = frame_base(bank_m);
    for (int i = 0; i < TB_FRAME; i++) exp_data_q.push_back(mkword(tag, i));
    for (int w = 0; w < TB_FRAME; w += TB_BURST) begin
      len = (TB_FRAME - w >= TB_BURST) ? TB_BURST : TB_FRAME - w;
      exp_addr_q.push_back(base + 30'(w * 8));
      exp_bl_q.push_back(7'(len - 1));
    end
    done_exp++;
`ifdef FRAME_PINGPONG_EN
    bank_m = ~bank_m;
`endif
  endtask

  task automatic send_words(input logic [7:0] tag, input int n, input bit with_edge);
    for (int i = 0; i < n; i++) begin
      pix_we   = 1'b1;
      pix_data = mkword(tag, i);
      vin_vs   = with_edge && (i == 0);
      tick();
    end
    pix_we = 1'b0;
    vin_vs = 1'b0;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while ((exp_data_q.size() != 0 || exp_addr_q.size() != 0) && c < 3000) begin
      tick();
      c++;
    end
    checks++;
    if (exp_data_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d beats and %0d commands outstanding, required 0",
               name, exp_data_q.size(), exp_addr_q.size());
      exp_data_q.delete();
      exp_addr_q.delete();
      exp_bl_q.delete();
    end
    repeat (5) tick();
    chk({name, " done_count"}, 64'(done_seen), 64'(done_exp));
    chk({name, " wr_bank"}, 64'(wr_bank), 64'(bank_m));
  endtask

  // Monitor: compares every handshake against the scoreboard queues
  logic [63:0] mon_d;
  logic        pend_q = 1'b0;
  logic [29:0] pend_addr;
  logic [6:0]  pend_bl;
  always @(negedge clk) begin
    if (pend_q && rst_n && init_done) begin
      checks++;
      if (!cmd_valid || cmd_addr !== pend_addr || cmd_bl !== pend_bl) begin
        errors++;
        $display("FAIL cmd_stable: got valid=%b addr=%h bl=%0d, required valid=1 addr=%h bl=%0d",
                 cmd_valid, cmd_addr, cmd_bl, pend_addr, pend_bl);
      end
    end
    pend_q    = cmd_valid && !cmd_ready;
    pend_addr = cmd_addr;
    pend_bl   = cmd_bl;

    if (wr_valid && wr_ready) begin
      checks++;
      if (exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL wr_beat: got %h, required no beat", wr_data);
      end else begin
        mon_d = exp_data_q.pop_front();
        if (wr_data !== mon_d) begin
          errors++;
          $display("FAIL wr_beat: got %h, required %h", wr_data, mon_d);
        end else begin
          $display("beat data=%h", wr_data);
        end
      end
    end

    if (cmd_valid && cmd_ready) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL cmd: got addr=%h bl=%0d, required no command", cmd_addr, cmd_bl);
        pend_q = 1'b0;
      end else begin
        if (cmd_addr !== exp_addr_q[0] || cmd_bl !== exp_bl_q[0]) begin
          errors++;
          $display("FAIL cmd: got addr=%h bl=%0d, required addr=%h bl=%0d",
                   cmd_addr, cmd_bl, exp_addr_q[0], exp_bl_q[0]);
        end else begin
          $display("cmd addr=%h bl=%0d", cmd_addr, cmd_bl);
        end
        void'(exp_addr_q.pop_front());
        void'(exp_bl_q.pop_front());
      end
    end

    if (frame_write_done) begin
      done_seen++;
      $display("frame_write_done pulse %0d", done_seen);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b1;
    init_done = 1'b0;
    vin_vs    = 1'b0;
    pix_we    = 1'b0;
    pix_data  = '0;
    wr_ready  = 1'b1;
    cmd_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    chk("rst wr_valid", 64'(wr_valid), 64'(0));
    chk("rst cmd_valid", 64'(cmd_valid), 64'(0));
    chk("rst cmd_addr", 64'(cmd_addr), 64'(TB_BASE));
    chk("rst cmd_bl", 64'(cmd_bl), 64'(0));
    chk("rst done", 64'(frame_write_done), 64'(0));
    chk("rst overflow", 64'(overflow), 64'(0));
    chk("rst wr_bank", 64'(wr_bank), 64'(0));
    rst_n = 1'b1;
    tick();

    // Pixels before calibration (even with an edge) and after it without an edge are ignored
    send_words(8'h01, 8, 1'b1);
    init_done = 1'b1;
    tick();
    send_words(8'h01, 8, 1'b0);
    repeat (30) tick();
    chk("pre-edge wr_valid", 64'(wr_valid), 64'(0));
    chk("pre-edge cmd_valid", 64'(cmd_valid), 64'(0));

    // Full frame back to back, word 0 coincident with the edge
    expect_frame(8'h02);
    send_words(8'h02, TB_FRAME, 1'b1);
    drain("frame_b2b");

    // Throttled pixels with both ready signals toggling
    expect_frame(8'h03);
    begin
      int i;
      i = 0;
      for (int c = 0; c < 400; c++) begin
        wr_ready  = (c % 2 == 0);
        cmd_ready = (c % 3 == 0);
        if (c % 4 == 0 && i < TB_FRAME) begin
          pix_we   = 1'b1;
          pix_data = mkword(8'h03, i);
          vin_vs   = (i == 0);
          i++;
        end else begin
          pix_we = 1'b0;
          vin_vs = 1'b0;
        end
        tick();
      end
    end
    pix_we    = 1'b0;
    vin_vs    = 1'b0;
    wr_ready  = 1'b1;
    cmd_ready = 1'b1;
    drain("frame_throttled");

    // Frame-start edge after 10 words of a burst: partial command, restart at frame base
    wr_ready = 1'b0;
    for (int i = 0; i < 10; i++) exp_data_q.push_back(mkword(8'h04, i));
    exp_addr_q.push_back(frame_base(bank_m));
    exp_bl_q.push_back(7'd9);
    send_words(8'h04, TB_BURST, 1'b1);
    begin
      int c;
      c = 0;
      while (!wr_valid && c < 50) begin
        tick();
        c++;
      end
      chk("abort wr_valid reached", 64'(wr_valid), 64'(1));
    end
    wr_ready = 1'b1;
    repeat (10) tick();
    wr_ready = 1'b0;
    vin_vs   = 1'b1;
    tick();
    vin_vs = 1'b0;
    chk("abort cmd_valid", 64'(cmd_valid), 64'(1));
    chk("abort cmd_bl", 64'(cmd_bl), 64'(9));
    tick();
    repeat (3) tick();
    chk("abort flushed wr_valid", 64'(wr_valid), 64'(0));
    wr_ready = 1'b1;
    expect_frame(8'h05);
    send_words(8'h05, TB_FRAME, 1'b0);
    drain("frame_after_abort");

    // Overflow: stalled write channel, then cleared by the next edge
    wr_ready = 1'b0;
    send_words(8'h06, TB_FRAME, 1'b1);
    tick();
    chk("overflow set", 64'(overflow), 64'(1));
    chk("overflow stalled wr_valid", 64'(wr_valid), 64'(1));
    vin_vs = 1'b1;
    tick();
    vin_vs = 1'b0;
    chk("overflow cleared", 64'(overflow), 64'(0));
    chk("overflow flushed wr_valid", 64'(wr_valid), 64'(0));
    wr_ready = 1'b1;
    expect_frame(8'h07);
    send_words(8'h07, TB_FRAME, 1'b0);
    drain("frame_after_overflow");
    chk("overflow stays clear", 64'(overflow), 64'(0));

    // Asynchronous reset mid-burst
    wr_ready = 1'b0;
    send_words(8'h08, 20, 1'b1);
    repeat (2) tick();
    chk("pre-reset wr_valid", 64'(wr_valid), 64'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("async rst wr_valid", 64'(wr_valid), 64'(0));
    chk("async rst cmd_valid", 64'(cmd_valid), 64'(0));
    chk("async rst cmd_addr", 64'(cmd_addr), 64'(TB_BASE));
    chk("async rst cmd_bl", 64'(cmd_bl), 64'(0));
    chk("async rst wr_bank", 64'(wr_bank), 64'(0));
    bank_m = 1'b0;
    tick();
    rst_n    = 1'b1;
    wr_ready = 1'b1;
    tick();
    send_words(8'h09, 10, 1'b0);
    repeat (20) tick();
    chk("post-reset ignored wr_valid", 64'(wr_valid), 64'(0));
    chk("post-reset ignored cmd_valid", 64'(cmd_valid), 64'(0));
    expect_frame(8'h0A);
    send_words(8'h0A, TB_FRAME, 1'b1);
    drain("frame_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_write_burst.md
FRAME_WRITE_BURST -- requirements
Module: frame_write_burst

Interface
REQ-001 SHALL have parameter BURST_LEN, default 64, meaning 64-bit words per DDR write burst (1..64).
REQ-002 SHALL have parameter FRAME_WORDS, default 76800, meaning 64-bit words per frame (640x480x16bpp/64).
REQ-003 SHALL have parameter BASE_ADDR, default 0, meaning byte address of frame buffer 0.
REQ-004 SHALL have parameter FIFO_DEPTH, default 256, meaning internal word buffer depth (power of two, >= 2*BURST_LEN).
REQ-005 SHALL have port clk, in, 1, the single clock (DDR user clock); ports are listed clock and reset first.
REQ-006 SHALL have port rst_n, in, 1; reset is asynchronous, active-low.
REQ-007 SHALL have port init_done, in, 1, high when DDR calibration and CMOS configuration are complete.
REQ-008 SHALL have port vin_vs, in, 1, camera vsync (already synchronised to clk); a rising edge marks frame start.
REQ-009 SHALL have ports pix_we (in, 1) and pix_data (in, 64), the packed pixel word stream from capture; no backpressure.
REQ-010 SHALL have ports wr_valid (out, 1), wr_ready (in, 1), wr_data (out, 64), the DDR write-data channel.
REQ-011 SHALL have ports cmd_valid (out, 1), cmd_ready (in, 1), cmd_addr (out, 30, byte address), cmd_bl (out, 7, burst length minus 1), the DDR write-command channel.
REQ-012 SHALL have ports frame_write_done (out, 1, one-cycle pulse), overflow (out, 1, sticky), wr_bank (out, 1, buffer being written).

Function
REQ-013 SHALL detect a vin_vs rising edge by comparing it with a one-cycle registered copy; pix_we is ignored until init_done is high and a first edge has been seen.
REQ-014 SHALL push pix_data into the FIFO on pix_we when not full; when full, the word SHALL be dropped and overflow set until the next frame start.
REQ-015 SHALL implement states IDLE, WAIT_DATA, DATA, CMD: IDLE->WAIT_DATA on first edge with init_done; WAIT_DATA->DATA when FIFO level >= min(BURST_LEN, words remaining in frame).
REQ-016 In DATA, it SHALL assert wr_valid with wr_data equal to the FIFO head; one word pops per cycle with wr_valid&&wr_ready; after the burst count is reached the next state is CMD.
REQ-017 In CMD, it SHALL hold cmd_valid, cmd_addr and cmd_bl stable until cmd_ready; on the handshake, address += 8*burst words, and the next state is WAIT_DATA, or IDLE-armed-for-next-edge if the frame word count equals FRAME_WORDS.
REQ-018 The final burst SHALL have length FRAME_WORDS mod BURST_LEN when non-zero; frame_write_done SHALL pulse on the cycle after the last command handshake.
REQ-019 Minimum latency SHALL be 2 clk from a pix_we write to that word on wr_data, given an eligible FIFO level.
REQ-020 On a frame-start edge mid-frame, the FIFO SHALL clear in the same cycle; if in DATA with k>0 words sent, it SHALL go to CMD with cmd_bl=k-1, else to WAIT_DATA; word and address counters SHALL restart at the new frame base; frame_write_done SHALL NOT pulse.
REQ-021 A simultaneous push and pop SHALL leave the FIFO level unchanged; a push coincident with a frame-start edge SHALL be stored as word 0 of the new frame.
REQ-022 Counters SHALL be wide enough for FRAME_WORDS and SHALL NOT wrap within a frame.

Reset
REQ-023 On rst_n low: state IDLE, FIFO empty, wr_valid=0, cmd_valid=0, cmd_addr=BASE_ADDR, cmd_bl=0, frame_write_done=0, overflow=0, wr_bank=0; all asynchronous.
REQ-024 init_done falling SHALL return the block to IDLE with the FIFO flushed, without waiting for handshakes.

Configuration
REQ-025 With FRAME_PINGPONG_EN defined, wr_bank SHALL toggle at each completed frame, and frame base SHALL be BASE_ADDR + wr_bank*FRAME_WORDS*8; aborted frames SHALL not toggle it.
REQ-026 Without FRAME_PINGPONG_EN, wr_bank SHALL be constant 0, and every frame SHALL start at BASE_ADDR.

Structure
REQ-027 A shared package ddr_frame_pkg SHALL hold the state encoding, default BURST_LEN/FRAME_WORDS constants and the address width (30).
REQ-028 The FIFO SHALL be a separate sub-module wr_fifo_sync (single-clock, first-word-fall-through, level output).

Verification
REQ-029 Edge, then 76800 words back-to-back, with wr_ready=cmd_ready=1 -> 1200 commands, addresses 0,512,...,613888, each cmd_bl=63, one frame_write_done pulse.
REQ-030 FRAME_WORDS=100, BURST_LEN=64 -> commands with bl 63 then 35, at addresses 0 and 512.
REQ-031 Stall wr_ready for 300 cycles while words stream in -> overflow=1 after 256 stored; cleared at next edge.
REQ-032 Edge after 40 words of a burst -> command bl=39, FIFO empty, next burst at address BASE_ADDR, no done pulse.
REQ-033 FRAME_PINGPONG_EN with 3 full frames -> wr_bank 0,1,0, second frame starts at 614400.
REQ-034 Assert rst_n low mid-burst -> all outputs reach reset values asynchronously; words after reset are ignored until init_done and an edge.
